store_byte_merge: RTL and testbench



---
 rtl/store_byte_merge_pkg.sv | 14 +
 rtl/store_byte_merge_byte_lane_merge.sv | 11 +
 rtl/store_byte_merge.sv | 71 +++++++
 tb/tb_store_byte_merge.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/store_byte_merge_pkg.sv
// store_byte_merge_pkg: store sizes, data width and state encodings for the store merge path
package store_byte_merge_pkg;
  localparam int DATA_W = 16;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERR     = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/store_byte_merge_byte_lane_merge.sv
// byte_lane_merge: replaces one byte lane of a 16-bit word with a new byte
module byte_lane_merge
  import store_byte_merge_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [7:0]        new_byte,
  input  logic              lane,
  output logic [DATA_W-1:0] merged
);
  assign merged = lane ? {new_byte, old_word[7:0]} : {old_word[15:8], new_byte};
endmodule

// File: rtl/store_byte_merge.sv
// store_byte_merge: byte/halfword stores into 16-bit word memory, read-modify-write for bytes
module store_byte_merge
  import store_byte_merge_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_size,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] byte_q;
  logic [DATA_W-1:0] wdata_q, merged;
  logic hs;
  assign hs = st_valid && st_ready;
  byte_lane_merge u_merge (
    .old_word(mem_rdata),
    .new_byte(byte_q),
    .lane(addr_q[0]),
    .merged(merged)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !hs ? IDLE : st_size == SIZE_HALF ? (st_addr[0] ? ERR : WR) : RD;
      RD:      state_nx = RD_WAIT;
      RD_WAIT: state_nx = mem_rvalid ? WR : RD_WAIT;
      WR:      state_nx = mem_wack ? DONE : WR;
      default: state_nx = IDLE;
    endcase
  end
  // halfword data is latched as the write word; byte stores overwrite it with the merge result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        addr_q  <= st_addr;
        byte_q  <= st_data[7:0];
        wdata_q <= st_data;
      end else if (state == RD_WAIT && mem_rvalid) begin
        wdata_q <= merged;
      end
    end
  end
  assign st_ready   = state == IDLE;
  assign misaligned = state == ERR;
  assign mem_re     = state == RD;
  assign mem_we     = state == WR;
  assign done       = state == DONE;
  assign mem_addr   = addr_q[ADDR_W-1:1];
  assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_store_byte_merge.sv
// tb_store_byte_merge: directed stores with a scoreboard of expected memory writes and rejects
module tb_store_byte_merge;
  import store_byte_merge_pkg::*;
  typedef struct packed {
    logic        err;
    logic [6:0]  addr;
    logic [15:0] wdata;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic st_valid = 0, st_size = 0;
  logic st_ready, done, misaligned, mem_re, mem_we;
  logic [7:0] st_addr = 0;
  logic [15:0] st_data = 0, mem_rdata, mem_wdata;
  logic [6:0] mem_addr;
  logic mem_rvalid = 0, mem_wack = 0;
  logic [15:0] rd_word = 0;
  int rd_lat = 1, wk_lat = 0, rd_cnt = 0, wr_cnt = 0;
  int checks = 0, errors = 0;
  int re_cnt = 0, done_cnt = 0, we_cyc = 0;
  exp_t sb[$];
  store_byte_merge #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .done(done),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wack(mem_wack)
  );
  assign mem_rdata = rd_word;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // memory model: read data rd_lat cycles after mem_re, ack after wk_lat extra WR cycles
  initial forever begin
    @(posedge clk); #1;
    mem_rvalid = 0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      mem_rvalid = (rd_cnt == 0);
    end
    if (mem_re) rd_cnt = rd_lat;
    mem_wack = mem_we && (wr_cnt == wk_lat);
    wr_cnt = mem_we ? wr_cnt + 1 : 0;
  end
  // monitor: every write cycle must present the expected word; pop on ack or reject
  always @(negedge clk) begin
    if (mem_re) re_cnt++;
    if (done) done_cnt++;
    if (mem_we) begin
      we_cyc++;
      if (sb.size() == 0) check("unexpected_write", 1, 0);
      else begin
        check("wr_addr", 32'(mem_addr), 32'(sb[0].addr));
        check("wr_data", 32'(mem_wdata), 32'(sb[0].wdata));
        check("wr_kind", 32'(sb[0].err), 0);
        if (mem_wack) void'(sb.pop_front());
      end
    end
    if (misaligned) begin
      if (sb.size() == 0) check("unexpected_misaligned", 1, 0);
      else begin
        check("mis_kind", 32'(sb[0].err), 1);
        void'(sb.pop_front());
      end
    end
  end
  task automatic do_store(input logic [7:0] a, input logic [15:0] d, input logic sz,
                          input int rl, input int wl, input logic [15:0] rdata,
                          input logic err, input logic [15:0] ew,
                          input int ek_we, input int ek_end, input int ex_re, input int ex_wc);
    int we_k, end_k, re0, dn0, wc0;
    rd_lat = rl; wk_lat = wl; rd_word = rdata;
    sb.push_back('{err, a[7:1], ew});
    re0 = re_cnt; dn0 = done_cnt; wc0 = we_cyc;
    check("ready_before", 32'(st_ready), 1);
    st_addr = a; st_data = d; st_size = sz; st_valid = 1;
    @(posedge clk); #1;
    st_valid = 0;
    we_k = 0; end_k = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_we && we_k == 0) we_k = k;
      if (done || misaligned) begin
        end_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("end_latency", 32'(end_k), 32'(ek_end));
    check("we_latency", 32'(we_k), 32'(ek_we));
    @(posedge clk); #1;
    check("ready_after", 32'(st_ready), 1);
    check("re_pulses", 32'(re_cnt - re0), 32'(ex_re));
    check("done_pulses", 32'(done_cnt - dn0), err ? 0 : 1);
    check("we_cycles", 32'(we_cyc - wc0), 32'(ex_wc));
  endtask
  initial begin
    int dn0, wc0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(st_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_mis", 32'(misaligned), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    // aligned halfword, zero-wait ack
    do_store(8'h10, 16'hBEEF, SIZE_HALF, 1, 0, 16'h0000, 0, 16'hBEEF, 1, 2, 0, 1);
    // byte lane 1, read data after 3 wait cycles
    do_store(8'h11, 16'hAA55, SIZE_BYTE, 4, 0, 16'h1234, 0, 16'h5534, 6, 7, 1, 1);
    // byte lane 0, zero-wait memory
    do_store(8'h10, 16'h00C3, SIZE_BYTE, 1, 0, 16'h1234, 0, 16'h12C3, 3, 4, 1, 1);
    // misaligned halfword
    do_store(8'h05, 16'h1111, SIZE_HALF, 1, 0, 16'h0000, 1, 16'h0000, 0, 1, 0, 0);
    // byte lane 1 with 4-cycle ack delay
    do_store(8'h23, 16'hFF7E, SIZE_BYTE, 1, 4, 16'hABCD, 0, 16'h7ECD, 3, 8, 1, 5);
    // byte lane 0 with upper data bits that must be ignored
    do_store(8'hFE, 16'hFF00, SIZE_BYTE, 2, 1, 16'h5AA5, 0, 16'h5A00, 4, 6, 1, 2);
    // reset while waiting for read data; the late rvalid must not produce a write
    dn0 = done_cnt; wc0 = we_cyc;
    rd_lat = 5; rd_word = 16'h9999;
    st_addr = 8'h40; st_data = 16'h0077; st_size = SIZE_BYTE; st_valid = 1;
    @(posedge clk); #1;
    st_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(st_ready), 0);
    rst_n = 0;
    #1;
    check("async_rst_ready", 32'(st_ready), 1);
    check("async_rst_re", 32'(mem_re), 0);
    check("async_rst_addr", 32'(mem_addr), 0);
    @(negedge clk) rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(st_ready), 1);
    check("post_rst_done", 32'(done_cnt - dn0), 0);
    check("post_rst_we", 32'(we_cyc - wc0), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
